// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types for the LC-3b instruction fetch stage
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        pcmux_plus2   = 3'b000,
        pcmux_br      = 3'b001,
        pcmux_reg     = 3'b010,
        pcmux_trap    = 3'b011,
        pcmux_pred    = 3'b100,
        pcmux_recover = 3'b101
    } lc3b_pcmux_sel;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Saturating counter increment; the counter sticks at all-ones.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'b0, inc};
        sat_add = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_target_mux.sv
// rtl/fetch_target_mux.sv - next-PC select, pc_plus2 for unused encodings
module fetch_target_mux
    import fetch_unit_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic [2:0]        sel,
    input  logic [WORD_W-1:0] pc_plus2,
    input  logic [WORD_W-1:0] br_target,
    input  logic [WORD_W-1:0] reg_target,
    input  logic [WORD_W-1:0] trap_target,
    input  logic [WORD_W-1:0] predicted_pc,
    input  logic [WORD_W-1:0] recover_pc,
    output logic [WORD_W-1:0] target
);

    // Select the redirect source; reserved encodings fall through sequentially.
    always_comb begin
        target = pc_plus2;
        case (lc3b_pcmux_sel'(sel))
            pcmux_br:      target = br_target;
            pcmux_reg:     target = reg_target;
            pcmux_trap:    target = trap_target;
            pcmux_pred:    target = predicted_pc;
            pcmux_recover: target = recover_pc;
            default:       target = pc_plus2;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, icache handshake, IF/ID register (optional FETCH_PERF_EN counters)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                WORD_W   = 16,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        pcmux_sel,
    input  logic [WORD_W-1:0] predicted_pc,
    input  logic [WORD_W-1:0] br_target,
    input  logic [WORD_W-1:0] reg_target,
    input  logic [WORD_W-1:0] trap_target,
    input  logic [WORD_W-1:0] recover_pc,
    input  logic              flush,
    input  logic              stall,
    input  logic [WORD_W-1:0] icache_rdata,
    input  logic              icache_resp,
    output logic              icache_read,
    output logic [WORD_W-1:0] icache_address,
    output logic [WORD_W-1:0] if_pc,
    output logic [WORD_W-1:0] ifid_pc,
    output logic [WORD_W-1:0] ifid_ir,
    output logic              ifid_valid,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_squash_cnt
);

    fetch_state_t      state, state_next;
    logic [WORD_W-1:0] pc, pc_next, pc_plus2, target;
    logic [WORD_W-1:0] redirect_pc, redirect_next;
    logic [WORD_W-1:0] hold_ir, hold_next;
    logic [WORD_W-1:0] ifid_pc_next, ifid_ir_next;
    logic              ifid_valid_next, ifid_load;

    assign pc_plus2 = pc + WORD_W'(2);

    fetch_target_mux #(.WORD_W(WORD_W)) u_target_mux (
        .sel          (pcmux_sel),
        .pc_plus2     (pc_plus2),
        .br_target    (br_target),
        .reg_target   (reg_target),
        .trap_target  (trap_target),
        .predicted_pc (predicted_pc),
        .recover_pc   (recover_pc),
        .target       (target)
    );

    // pc never moves while draining, so the cache sees a stable address.
    assign icache_read    = ~rst & (state != HOLD);
    assign icache_address = pc;
    assign if_pc          = pc;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    // Next-state and datapath decisions; flush outranks stall and the response.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        redirect_next   = redirect_pc;
        hold_next       = hold_ir;
        ifid_load       = 1'b0;
        ifid_ir_next    = ifid_ir;
        ifid_pc_next    = ifid_pc;
        ifid_valid_next = ifid_valid;
        case (state)
            FETCH: begin
                if (flush) begin
                    ifid_valid_next = 1'b0;
                    hold_next       = '0;
                    if (icache_resp) begin
                        pc_next = target;
                    end else begin
                        redirect_next = target;
                        state_next    = DRAIN;
                    end
                end else if (icache_resp) begin
                    if (stall) begin
                        hold_next  = icache_rdata;
                        state_next = HOLD;
                    end else begin
                        ifid_load    = 1'b1;
                        ifid_ir_next = icache_rdata;
                        pc_next      = target;
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    ifid_valid_next = 1'b0;
                    hold_next       = '0;
                    pc_next         = target;
                    state_next      = FETCH;
                end else if (!stall) begin
                    ifid_load    = 1'b1;
                    ifid_ir_next = hold_ir;
                    pc_next      = target;
                    state_next   = FETCH;
                end
            end
            DRAIN: begin
                if (flush) begin
                    ifid_valid_next = 1'b0;
                    hold_next       = '0;
                    if (icache_resp) begin
                        pc_next    = target;
                        state_next = FETCH;
                    end else begin
                        redirect_next = target;
                    end
                end else if (icache_resp) begin
                    pc_next    = redirect_pc;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
        if (ifid_load) begin
            ifid_pc_next    = pc_plus2;
            ifid_valid_next = 1'b1;
        end
    end

    // PC, redirect, hold and IF/ID registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            redirect_pc <= '0;
            hold_ir     <= '0;
            ifid_pc     <= '0;
            ifid_ir     <= '0;
            ifid_valid  <= 1'b0;
        end else begin
            pc          <= pc_next;
            redirect_pc <= redirect_next;
            hold_ir     <= hold_next;
            ifid_pc     <= ifid_pc_next;
            ifid_ir     <= ifid_ir_next;
            ifid_valid  <= ifid_valid_next;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, squash_cnt;
    logic        dropped, flushed_valid;

    assign dropped       = icache_resp & ((state == FETCH & flush) | (state == DRAIN));
    assign flushed_valid = flush & ifid_valid;

    // Saturating event counters for loaded and squashed instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            fetch_cnt  <= sat_add(fetch_cnt, {1'b0, ifid_load});
            squash_cnt <= sat_add(squash_cnt, {1'b0, dropped} + {1'b0, flushed_valid});
        end
    end

    assign perf_fetch_cnt  = fetch_cnt;
    assign perf_squash_cnt = squash_cnt;
`else
    assign perf_fetch_cnt  = '0;
    assign perf_squash_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  pcmux_sel = '0;
    logic [15:0] predicted_pc = '0, br_target = '0, reg_target = '0;
    logic [15:0] trap_target = '0, recover_pc = '0, icache_rdata = '0;
    logic        flush = 1'b0, stall = 1'b0, icache_resp = 1'b0;
    logic        icache_read, ifid_valid;
    logic [15:0] icache_address, if_pc, ifid_pc, ifid_ir;
    logic [31:0] perf_fetch_cnt, perf_squash_cnt;

    int checks = 0;
    int errors = 0;

    // Reference: phase 0 = requesting, 1 = holding a stalled word, 2 = waiting out a redirected read
    logic [15:0] m_pc, m_ifid_pc, m_ifid_ir, m_hold, m_redirect;
    logic        m_valid;
    int          m_phase;
    int unsigned m_fetches, m_squash;

    fetch_unit dut (
        .clk(clk), .rst(rst), .pcmux_sel(pcmux_sel), .predicted_pc(predicted_pc),
        .br_target(br_target), .reg_target(reg_target), .trap_target(trap_target),
        .recover_pc(recover_pc), .flush(flush), .stall(stall),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .icache_read(icache_read), .icache_address(icache_address), .if_pc(if_pc),
        .ifid_pc(ifid_pc), .ifid_ir(ifid_ir), .ifid_valid(ifid_valid),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_squash_cnt(perf_squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 16'h0000; m_ifid_pc = '0; m_ifid_ir = '0; m_hold = '0; m_redirect = '0;
        m_valid = 1'b0; m_phase = 0; m_fetches = 0; m_squash = 0;
    endtask

    task automatic model_load(input logic [15:0] word);
        m_ifid_pc = m_pc + 16'd2;
        m_ifid_ir = word;
        m_valid   = 1'b1;
        m_fetches++;
    endtask

    task automatic model_step(input logic [2:0] s, input logic f, input logic st,
                              input logic r, input logic [15:0] rd);
        logic [15:0] cand [8];
        logic [15:0] tgt;
        cand[0] = m_pc + 16'd2; cand[1] = br_target; cand[2] = reg_target;
        cand[3] = trap_target;  cand[4] = predicted_pc; cand[5] = recover_pc;
        cand[6] = m_pc + 16'd2; cand[7] = m_pc + 16'd2;
        tgt = cand[s];
        if (f) begin
            if (m_valid) m_squash++;
            m_valid = 1'b0;
            m_hold  = '0;
            if (m_phase == 1) begin
                m_pc = tgt; m_phase = 0;
            end else if (r) begin
                m_squash++; m_pc = tgt; m_phase = 0;
            end else begin
                m_redirect = tgt; m_phase = 2;
            end
        end else if (m_phase == 0) begin
            if (r && st) begin
                m_hold = rd; m_phase = 1;
            end else if (r) begin
                model_load(rd); m_pc = tgt;
            end
        end else if (m_phase == 1) begin
            if (!st) begin
                model_load(m_hold); m_pc = tgt; m_phase = 0;
            end
        end else if (r) begin
            m_squash++; m_pc = m_redirect; m_phase = 0;
        end
    endtask

    // Called at a negedge; drives one cycle and returns at the next negedge.
    task automatic run_cycle(input logic [2:0] s, input logic f, input logic st,
                             input logic r, input logic [15:0] rd);
        pcmux_sel = s; flush = f; stall = st; icache_resp = r; icache_rdata = rd;
        model_step(s, f, st, r, rd);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; icache_resp = 1'b0;
    endtask

    task automatic jump_to(input logic [15:0] addr);
        trap_target = addr;
        run_cycle(3'b011, 1'b0, 1'b0, 1'b1, 16'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (icache_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b exp 0", icache_read); end
        checks++; if (if_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", if_pc); end
        checks++; if ({ifid_valid, ifid_pc, ifid_ir} !== 33'b0) begin errors++; $display("FAIL reset_ifid got %b/%h/%h exp 0", ifid_valid, ifid_pc, ifid_ir); end
        checks++; if ({perf_fetch_cnt, perf_squash_cnt} !== 64'b0) begin errors++; $display("FAIL reset_perf got %h/%h exp 0", perf_fetch_cnt, perf_squash_cnt); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        checks++; if (icache_read !== 1'b1 || icache_address !== 16'h0000) begin errors++; $display("FAIL first_req got %b/%h exp 1/0000", icache_read, icache_address); end
    endtask

    task automatic test_sequential();
        logic [15:0] exp_addr;
        for (int i = 0; i < 3; i++) begin
            exp_addr = 16'(2 * i);
            checks++; if (icache_address !== exp_addr) begin errors++; $display("FAIL seq_addr got %h exp %h", icache_address, exp_addr); end
            run_cycle(3'b000, 1'b0, 1'b0, 1'b1, 16'($urandom));
            checks++; if (ifid_pc !== exp_addr + 16'd2 || ifid_valid !== 1'b1 || ifid_ir !== m_ifid_ir) begin
                errors++; $display("FAIL seq_ifid got %h/%b/%h exp %h/1/%h", ifid_pc, ifid_valid, ifid_ir, exp_addr + 16'd2, m_ifid_ir);
            end
        end
    endtask

    task automatic test_predict();
        jump_to(16'h0010);
        predicted_pc = 16'h3000;
        run_cycle(3'b100, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        checks++; if (icache_address !== 16'h3000 || ifid_pc !== 16'h0012 || ifid_ir !== 16'hBEEF) begin
            errors++; $display("FAIL predict got %h/%h/%h exp 3000/0012/beef", icache_address, ifid_pc, ifid_ir);
        end
    endtask

    task automatic test_stall();
        run_cycle(3'b000, 1'b0, 1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 2; i++) begin
            checks++; if (icache_read !== 1'b0 || ifid_pc !== 16'h0012 || ifid_ir !== 16'hBEEF) begin
                errors++; $display("FAIL stall_hold got %b/%h/%h exp 0/0012/beef", icache_read, ifid_pc, ifid_ir);
            end
            run_cycle(3'b000, 1'b0, 1'b1, 1'b0, 16'h0);
        end
        run_cycle(3'b000, 1'b0, 1'b0, 1'b0, 16'h0);
        checks++; if (ifid_ir !== 16'h1234 || ifid_pc !== 16'h3002 || icache_address !== 16'h3002 || icache_read !== 1'b1) begin
            errors++; $display("FAIL stall_release got %h/%h/%h/%b exp 1234/3002/3002/1", ifid_ir, ifid_pc, icache_address, icache_read);
        end
    endtask

    task automatic test_flush_drain();
        int unsigned sq0;
        jump_to(16'h0020);
        sq0 = m_squash;
        recover_pc = 16'h0044;
        run_cycle(3'b101, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++; if (icache_address !== 16'h0020 || icache_read !== 1'b1 || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL drain_start got %h/%b/%b exp 0020/1/0", icache_address, icache_read, ifid_valid);
        end
        recover_pc = 16'h7777;
        run_cycle(3'b101, 1'b0, 1'b0, 1'b0, 16'h0);
        checks++; if (icache_address !== 16'h0020) begin errors++; $display("FAIL drain_stable got %h exp 0020", icache_address); end
        run_cycle(3'b000, 1'b0, 1'b0, 1'b1, 16'hDEAD);
        checks++; if (icache_address !== 16'h0044 || ifid_valid !== 1'b0 || ifid_ir === 16'hDEAD) begin
            errors++; $display("FAIL drain_done got %h/%b/%h exp 0044/0/not-dead", icache_address, ifid_valid, ifid_ir);
        end
        checks++; if (m_squash - sq0 !== 2) begin errors++; $display("FAIL drain_model_squash got %0d exp 2", m_squash - sq0); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_squash_cnt !== m_squash) begin errors++; $display("FAIL drain_perf got %0d exp %0d", perf_squash_cnt, m_squash); end
`endif
    endtask

    task automatic test_flush_resp();
        br_target = 16'h0100;
        run_cycle(3'b001, 1'b1, 1'b0, 1'b1, 16'hCAFE);
        checks++; if (icache_address !== 16'h0100 || ifid_valid !== 1'b0 || ifid_ir === 16'hCAFE) begin
            errors++; $display("FAIL flush_resp got %h/%b/%h exp 0100/0/not-cafe", icache_address, ifid_valid, ifid_ir);
        end
    endtask

    task automatic test_double_flush();
        reg_target = 16'h0200;
        run_cycle(3'b010, 1'b1, 1'b0, 1'b0, 16'h0);
        reg_target = 16'h0300;
        run_cycle(3'b010, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++; if (icache_address !== 16'h0100) begin errors++; $display("FAIL dflush_stable got %h exp 0100", icache_address); end
        run_cycle(3'b000, 1'b0, 1'b0, 1'b1, 16'h0);
        checks++; if (icache_address !== 16'h0300) begin errors++; $display("FAIL dflush_target got %h exp 0300", icache_address); end
    endtask

    task automatic test_wrap();
        jump_to(16'hFFFE);
        run_cycle(3'b000, 1'b0, 1'b0, 1'b1, 16'h5A5A);
        checks++; if (icache_address !== 16'h0000 || ifid_pc !== 16'h0000) begin
            errors++; $display("FAIL wrap got %h/%h exp 0000/0000", icache_address, ifid_pc);
        end
    endtask

    task automatic test_random();
        logic [2:0] s;
        logic f, st, r;
        for (int i = 0; i < 400; i++) begin
            predicted_pc = 16'($urandom); br_target = 16'($urandom); reg_target = 16'($urandom);
            trap_target = 16'($urandom); recover_pc = 16'($urandom);
            s  = 3'($urandom_range(0, 7));
            f  = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 3) == 0);
            r  = (m_phase != 1) && ($urandom_range(0, 1) == 1);
            run_cycle(s, f, st, r, 16'($urandom));
            checks++; if (icache_read !== (m_phase != 1) || icache_address !== m_pc || if_pc !== m_pc) begin
                errors++; $display("FAIL rand_req cyc %0d got %b/%h/%h exp %b/%h", i, icache_read, icache_address, if_pc, m_phase != 1, m_pc);
            end
            checks++; if (ifid_valid !== m_valid || ifid_pc !== m_ifid_pc || ifid_ir !== m_ifid_ir) begin
                errors++; $display("FAIL rand_ifid cyc %0d got %b/%h/%h exp %b/%h/%h", i, ifid_valid, ifid_pc, ifid_ir, m_valid, m_ifid_pc, m_ifid_ir);
            end
        end
`ifdef FETCH_PERF_EN
        checks++; if (perf_fetch_cnt !== m_fetches || perf_squash_cnt !== m_squash) begin
            errors++; $display("FAIL rand_perf got %0d/%0d exp %0d/%0d", perf_fetch_cnt, perf_squash_cnt, m_fetches, m_squash);
        end
`else
        checks++; if (perf_fetch_cnt !== 32'h0 || perf_squash_cnt !== 32'h0) begin
            errors++; $display("FAIL perf_tied got %h/%h exp 0/0", perf_fetch_cnt, perf_squash_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        jump_to(16'h0400);
        recover_pc = 16'h0500;
        run_cycle(3'b101, 1'b1, 1'b0, 1'b0, 16'h0);
        #2 rst = 1'b1;
        #1;
        checks++; if (icache_read !== 1'b0 || if_pc !== 16'h0000 || ifid_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset got %b/%h/%b exp 0/0000/0", icache_read, if_pc, ifid_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_cycle(3'b000, 1'b0, 1'b0, 1'b1, 16'h1111);
        checks++; if (icache_address !== 16'h0002 || ifid_ir !== 16'h1111 || ifid_valid !== 1'b1) begin
            errors++; $display("FAIL after_reset got %h/%h/%b exp 0002/1111/1", icache_address, ifid_ir, ifid_valid);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_predict();
        test_stall();
        test_flush_drain();
        test_flush_resp();
        test_double_flush();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
